// File: rtl/rvvi_trace_buffer_pkg.sv
// Shared types for the RVVI retirement trace buffer: core width, trace record
// layout, capture FSM states and trigger modes.
package core_pkg;
  localparam int XLEN = 32;
endpackage

package trace_pkg;
  localparam int TRACE_CYC_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_e;

  typedef enum logic [1:0] {
    MODE_FREE = 2'd0,  // never triggers
    MODE_TRAP = 2'd1,
    MODE_PC   = 2'd2,
    MODE_ANY  = 2'd3   // trap or PC match
  } trace_mode_e;

  typedef struct packed {
    logic [TRACE_CYC_W-1:0]    cycle;
    logic [1:0]                lane;
    logic                      trap;
    logic                      rd_we;
    logic [4:0]                rd_addr;
    logic [core_pkg::XLEN-1:0] rd_wdata;
    logic [31:0]               insn;
    logic [core_pkg::XLEN-1:0] pc;
  } trace_rec_t;
endpackage

// File: rtl/rvvi_trace_buffer_if.sv
// Retirement input bus and record drain port of the trace buffer.
interface rvvi_trace_buffer_if #(
  parameter int NRET = 2,
  parameter int XLEN = core_pkg::XLEN
) ();
  logic [NRET-1:0]           valid_i;
  logic [NRET-1:0][XLEN-1:0] pc_i;
  logic [NRET-1:0][31:0]     insn_i;
  logic [NRET-1:0]           trap_i;
  logic [NRET-1:0]           rd_we_i;
  logic [NRET-1:0][4:0]      rd_addr_i;
  logic [NRET-1:0][XLEN-1:0] rd_wdata_i;
  logic                      rd_valid_o;
  logic                      rd_ready_i;
  trace_pkg::trace_rec_t     rd_data_o;

  // Core/consumer side: drives retirements, pulls records.
  modport master (
    output valid_i, pc_i, insn_i, trap_i, rd_we_i, rd_addr_i, rd_wdata_i, rd_ready_i,
    input  rd_valid_o, rd_data_o
  );

  // Trace buffer side.
  modport slave (
    input  valid_i, pc_i, insn_i, trap_i, rd_we_i, rd_addr_i, rd_wdata_i, rd_ready_i,
    output rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/rvvi_trace_ram.sv
// Circular record storage: NRET write ports at distinct compacted addresses,
// one asynchronous read port for the drain side.
module rvvi_trace_ram
  import trace_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic [NRET-1:0]          we_i,
  input  logic [NRET-1:0][AW-1:0]  waddr_i,
  input  trace_rec_t [NRET-1:0]    wdata_i,
  input  logic [AW-1:0]            raddr_i,
  output trace_rec_t               rdata_o
);
  trace_rec_t mem_q [DEPTH];

  // Per-lane writes; compaction guarantees the addresses never collide.
  // NOTE: the array has no reset -- validity is tracked by the count and
  // pointers in the top, so clearing storage would only cost reset fan-out.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NRET; l++) begin
      if (we_i[l]) mem_q[waddr_i[l]] <= wdata_i[l];
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/rvvi_trace_buffer.sv
// Trigger-centred retirement trace buffer: captures compacted RVVI records into
// a circular RAM, freezes after a post-trigger window and drains oldest first.
module rvvi_trace_buffer
  import trace_pkg::*;
#(
  parameter int NRET      = 2,
  parameter int XLEN      = core_pkg::XLEN,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  rvvi_trace_buffer_if.slave       bus,
  input  logic                     arm_i,
  input  logic                     clr_i,
  input  logic [1:0]               mode_i,
  input  logic [XLEN-1:0]          trig_pc_i,
  output trace_state_e             state_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trace_state_e               state_q;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d, post_cnt_q;
  logic                       overflow_q, rd_valid_q;
  logic [TRACE_CYC_W-1:0]     cyc_q;

  trace_mode_e                mode;
  logic [NRET-1:0]            lane_trig;
  logic [NRET-1:0]            wr_en;
  logic [NRET-1:0][AW-1:0]    wr_addr;
  trace_rec_t [NRET-1:0]      wr_data;
  logic [CW-1:0]              n_wr, post_left, sum;
  logic                       trig_seen, stop, ovf_now, capture;
  trace_rec_t                 ram_rd;

  // Per-lane trigger qualification from the selected mode.
  always_comb begin
    mode = trace_mode_e'(mode_i);
    for (int l = 0; l < NRET; l++) begin
      lane_trig[l] = ((mode == MODE_TRAP || mode == MODE_ANY) && bus.trap_i[l]) ||
                     ((mode == MODE_PC   || mode == MODE_ANY) && bus.pc_i[l] == trig_pc_i);
    end
  end

  // Lane compaction, trigger detection and post-window accounting, oldest lane first.
  // NOTE: blocking assignments here model a ripple through the lanes; every
  // output gets a default first so no latch is inferred.
  always_comb begin
    wr_en     = '0;
    wr_addr   = '0;
    n_wr      = '0;
    capture   = (state_q == ARMED) || (state_q == POST);
    trig_seen = (state_q == POST);
    post_left = post_cnt_q;
    stop      = 1'b0;
    for (int l = 0; l < NRET; l++) begin
      wr_data[l] = '{cycle: cyc_q, lane: 2'(l), trap: bus.trap_i[l], rd_we: bus.rd_we_i[l],
                     rd_addr: bus.rd_addr_i[l], rd_wdata: bus.rd_wdata_i[l],
                     insn: bus.insn_i[l], pc: bus.pc_i[l]};
      if (capture && bus.valid_i[l] && !stop) begin
        if (state_q == ARMED && !trig_seen && lane_trig[l]) begin
          trig_seen = 1'b1;
          post_left = CW'(POST_TRIG);
        end
        wr_en[l]   = 1'b1;
        wr_addr[l] = wr_ptr_q + n_wr[AW-1:0];
        n_wr       = n_wr + CW'(1);
        if (trig_seen) begin
          post_left = post_left - CW'(1);
          if (post_left == '0) stop = 1'b1;
        end
      end
    end
  end

  // Occupancy with saturation; the oldest entry always sits count entries behind the writer.
  always_comb begin
    sum      = count_q + n_wr;
    ovf_now  = sum > CW'(DEPTH);
    count_d  = ovf_now ? CW'(DEPTH) : sum;
    wr_ptr_d = wr_ptr_q + n_wr[AW-1:0];
    rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
  end

  // Free-running cycle stamp shared by all lanes of a cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cyc_q <= '0;
    else       cyc_q <= cyc_q + 1'b1;
  end

  // Capture/drain FSM with pointers, counters and registered drain valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else if (clr_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (arm_i) begin
          state_q    <= ARMED;
          wr_ptr_q   <= '0;
          rd_ptr_q   <= '0;
          count_q    <= '0;
          overflow_q <= 1'b0;
        end
        ARMED, POST: begin
          wr_ptr_q   <= wr_ptr_d;
          rd_ptr_q   <= rd_ptr_d;
          count_q    <= count_d;
          post_cnt_q <= post_left;
          if (ovf_now)        overflow_q <= 1'b1;
          if (stop)           state_q    <= DONE;
          else if (trig_seen) state_q    <= POST;
        end
        DONE: begin
          if (count_q == '0) begin
            state_q <= IDLE;
          end else if (!rd_valid_q) begin
            rd_valid_q <= 1'b1;
          end else if (bus.rd_ready_i) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_q - CW'(1);
            if (count_q == CW'(1)) begin
              state_q    <= IDLE;
              rd_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  rvvi_trace_ram #(.NRET(NRET), .DEPTH(DEPTH)) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rd)
  );

  assign bus.rd_valid_o = rd_valid_q;
  assign bus.rd_data_o  = rd_valid_q ? ram_rd : '0;
  assign state_o        = state_q;
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;
endmodule

// File: tb/tb_rvvi_trace_buffer.sv
// Directed bench for rvvi_trace_buffer: two instances (POST_TRIG 3 and 1,
// DEPTH 8) share one stimulus stream; expected records are built locally.
module tb_rvvi_trace_buffer;
  import trace_pkg::*;

  localparam int NRET  = 2;
  localparam int XLEN  = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                      arm = 1'b0, clr = 1'b0, rd_ready = 1'b0;
  logic [1:0]                mode = 2'd0;
  logic [XLEN-1:0]           trig_pc = '0;
  logic [NRET-1:0]           valid = '0, trap = '0;
  logic [NRET-1:0][XLEN-1:0] pc = '0;
  logic [NRET-1:0][31:0]     insn;
  logic [NRET-1:0][4:0]      rd_addr;
  logic [NRET-1:0][XLEN-1:0] wdata;

  trace_state_e  st_a, st_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic          ovf_a, ovf_b;
  logic [31:0]   tb_cyc;
  int            total = 0;
  int            bad = 0;
  trace_rec_t    qa[$];
  trace_rec_t    qb[$];
  trace_rec_t    held;

  rvvi_trace_buffer_if #(.NRET(NRET), .XLEN(XLEN)) ifa ();
  rvvi_trace_buffer_if #(.NRET(NRET), .XLEN(XLEN)) ifb ();

  always_comb begin
    for (int l = 0; l < NRET; l++) begin
      insn[l]    = pc[l] + 32'h13;
      rd_addr[l] = 5'(l + 1);
      wdata[l]   = ~pc[l];
    end
  end

  assign ifa.valid_i = valid;    assign ifb.valid_i = valid;
  assign ifa.pc_i = pc;          assign ifb.pc_i = pc;
  assign ifa.insn_i = insn;      assign ifb.insn_i = insn;
  assign ifa.trap_i = trap;      assign ifb.trap_i = trap;
  assign ifa.rd_we_i = '1;       assign ifb.rd_we_i = '1;
  assign ifa.rd_addr_i = rd_addr;  assign ifb.rd_addr_i = rd_addr;
  assign ifa.rd_wdata_i = wdata;   assign ifb.rd_wdata_i = wdata;
  assign ifa.rd_ready_i = rd_ready; assign ifb.rd_ready_i = rd_ready;

  rvvi_trace_buffer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(3)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(ifa), .arm_i(arm), .clr_i(clr), .mode_i(mode),
    .trig_pc_i(trig_pc), .state_o(st_a), .count_o(cnt_a), .overflow_o(ovf_a)
  );

  rvvi_trace_buffer #(.NRET(NRET), .XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(ifb), .arm_i(arm), .clr_i(clr), .mode_i(mode),
    .trig_pc_i(trig_pc), .state_o(st_b), .count_o(cnt_b), .overflow_o(ovf_b)
  );

  // Reference cycle stamp: counts clock edges seen out of reset.
  always @(posedge clk) begin
    if (rst) tb_cyc <= '0;
    else     tb_cyc <= tb_cyc + 1;
  end

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic trace_rec_t exp_rec(input logic [31:0] stamp, input int lane,
                                         input logic tr, input logic [XLEN-1:0] p);
    trace_rec_t r;
    r.cycle    = stamp;
    r.lane     = 2'(lane);
    r.trap     = tr;
    r.rd_we    = 1'b1;
    r.rd_addr  = 5'(lane + 1);
    r.rd_wdata = ~p;
    r.insn     = p + 32'h13;
    r.pc       = p;
    return r;
  endfunction

  initial begin
    // Reset values
    step();
    step();
    rst = 1'b0;
    check("rst_state", 192'(st_a), 192'(IDLE));
    check("rst_valid", 192'(ifa.rd_valid_o), 192'(0));
    check("rst_data", 192'(ifa.rd_data_o), 192'(0));
    check("rst_count", 192'(cnt_a), 192'(0));
    check("rst_ovf", 192'(ovf_a), 192'(0));

    // Wrap and overflow with no trigger: 10 cycles of two lanes into 8 entries
    mode = 2'd1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("arm_state", 192'(st_a), 192'(ARMED));
    for (int c = 1; c <= 10; c++) begin
      valid = 2'b11;
      pc[0] = 32'h100 + 32'(8 * c);
      pc[1] = 32'h104 + 32'(8 * c);
      step();
      if (c == 4) begin
        check("full_count", 192'(cnt_a), 192'(8));
        check("full_no_ovf", 192'(ovf_a), 192'(0));
      end
      if (c == 5) check("ovf_set", 192'(ovf_a), 192'(1));
    end
    valid = '0;
    check("wrap_count", 192'(cnt_a), 192'(8));
    check("wrap_ovf", 192'(ovf_a), 192'(1));
    check("wrap_state", 192'(st_a), 192'(ARMED));
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_state", 192'(st_a), 192'(IDLE));
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("rearm_ovf", 192'(ovf_a), 192'(0));
    check("rearm_count", 192'(cnt_a), 192'(0));

    // PC-match trigger on lane 1, then two single-lane cycles
    mode = 2'd2;
    trig_pc = 32'h8000_0010;
    valid = 2'b11; pc[0] = 32'h8000_0000; pc[1] = 32'h8000_0004;
    qa.push_back(exp_rec(tb_cyc, 0, 1'b0, pc[0]));
    qa.push_back(exp_rec(tb_cyc, 1, 1'b0, pc[1]));
    step();
    check("pc_pre_state", 192'(st_a), 192'(ARMED));
    pc[0] = 32'h8000_000C; pc[1] = 32'h8000_0010;
    qa.push_back(exp_rec(tb_cyc, 0, 1'b0, pc[0]));
    qa.push_back(exp_rec(tb_cyc, 1, 1'b0, pc[1]));
    step();
    check("pc_trig_state", 192'(st_a), 192'(POST));
    check("pc_trig_count", 192'(cnt_a), 192'(4));
    check("pc_b_done", 192'(st_b), 192'(DONE));
    check("pc_b_count", 192'(cnt_b), 192'(4));
    valid = 2'b01; pc[0] = 32'h8000_0014;
    qa.push_back(exp_rec(tb_cyc, 0, 1'b0, pc[0]));
    step();
    check("post1_state", 192'(st_a), 192'(POST));
    pc[0] = 32'h8000_0018;
    qa.push_back(exp_rec(tb_cyc, 0, 1'b0, pc[0]));
    step();
    valid = '0;
    check("post_done", 192'(st_a), 192'(DONE));
    check("post_count", 192'(cnt_a), 192'(6));
    check("done_valid_lo", 192'(ifa.rd_valid_o), 192'(0));
    step();
    check("done_valid_hi", 192'(ifa.rd_valid_o), 192'(1));
    check("drain_oldest", 192'(ifa.rd_data_o), 192'(qa[0]));

    // Stall pattern 1,0,0,1: exactly two pops, data held while stalled
    rd_ready = 1'b1;
    step();
    check("pop1_count", 192'(cnt_a), 192'(5));
    check("pop1_data", 192'(ifa.rd_data_o), 192'(qa[1]));
    held = ifa.rd_data_o;
    rd_ready = 1'b0;
    step();
    step();
    check("stall_data", 192'(ifa.rd_data_o), 192'(held));
    check("stall_count", 192'(cnt_a), 192'(5));
    rd_ready = 1'b1;
    step();
    check("pop2_count", 192'(cnt_a), 192'(4));
    for (int i = 2; i < 6; i++) begin
      check($sformatf("drain_%0d", i), 192'(ifa.rd_data_o), 192'(qa[i]));
      step();
    end
    check("drain_end_valid", 192'(ifa.rd_valid_o), 192'(0));
    check("drain_end_state", 192'(st_a), 192'(IDLE));
    check("drain_end_count", 192'(cnt_a), 192'(0));
    rd_ready = 1'b0;

    // Lane mask 2'b10, then trap on lane 0 with lane 1 valid (POST_TRIG=1 drops lane 1)
    mode = 2'd1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    valid = 2'b10; pc[0] = 32'h0; pc[1] = 32'h200;
    qb.push_back(exp_rec(tb_cyc, 1, 1'b0, pc[1]));
    step();
    check("mask_count", 192'(cnt_b), 192'(1));
    valid = 2'b11; trap = 2'b01; pc[0] = 32'h204; pc[1] = 32'h208;
    qb.push_back(exp_rec(tb_cyc, 0, 1'b1, pc[0]));
    step();
    valid = '0; trap = '0;
    check("trap_b_state", 192'(st_b), 192'(DONE));
    check("trap_b_count", 192'(cnt_b), 192'(2));
    check("trap_a_state", 192'(st_a), 192'(POST));
    check("trap_a_count", 192'(cnt_a), 192'(3));
    step();
    check("b_valid", 192'(ifb.rd_valid_o), 192'(1));
    check("b_slot0_lane1", 192'(ifb.rd_data_o), 192'(qb[0]));
    rd_ready = 1'b1;
    step();
    check("b_slot1_trap", 192'(ifb.rd_data_o), 192'(qb[1]));

    // Reset mid-drain
    rst = 1'b1;
    #1;
    check("mid_rst_state_b", 192'(st_b), 192'(IDLE));
    check("mid_rst_valid_b", 192'(ifb.rd_valid_o), 192'(0));
    check("mid_rst_data_b", 192'(ifb.rd_data_o), 192'(0));
    check("mid_rst_count_b", 192'(cnt_b), 192'(0));
    check("mid_rst_state_a", 192'(st_a), 192'(IDLE));
    check("mid_rst_count_a", 192'(cnt_a), 192'(0));
    step();
    rst = 1'b0;
    rd_ready = 1'b0;

    // clr_i during POST, with arm_i in the same cycle
    arm = 1'b1;
    step();
    arm = 1'b0;
    valid = 2'b01; trap = 2'b01; pc[0] = 32'h300;
    step();
    valid = '0; trap = '0;
    check("clr_pre_post", 192'(st_a), 192'(POST));
    clr = 1'b1;
    arm = 1'b1;
    step();
    clr = 1'b0;
    check("clr_wins_a", 192'(st_a), 192'(IDLE));
    check("clr_wins_b", 192'(st_b), 192'(IDLE));
    check("clr_valid_b", 192'(ifb.rd_valid_o), 192'(0));
    step();
    arm = 1'b0;
    check("restart_state", 192'(st_a), 192'(ARMED));
    check("restart_ovf", 192'(ovf_a), 192'(0));
    check("restart_count", 192'(cnt_a), 192'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
